// File: rtl/butterfly_pipe.sv
`default_nettype none
// ==========================================================================
// butterfly_pipe : 3-stage Cooley-Tukey / Gentleman-Sande butterfly mod Q
// Revision 1.0
// ==========================================================================
module butterfly_pipe #(
  parameter int DATA_W = 23,
  parameter int Q      = 8380417,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] twiddle_i,
  input  logic              sel_butterfly_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  op_count_o
);

  localparam logic [DATA_W:0]     Q_X = (DATA_W+1)'(Q);
  localparam logic [2*DATA_W-1:0] Q_P = (2*DATA_W)'(Q);

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_X) s = s - Q_X;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + Q_X - {1'b0, y};
    return DATA_W'(s);
  endfunction

  // Stage 1: x term and full-width product; stage 2: product reduced mod Q;
  // stage 3: final CT add/sub (GS passes straight through).
  logic                  s1_valid_q, s2_valid_q, valid_q;
  logic                  s1_sel_q, s2_sel_q;
  logic [DATA_W-1:0]     s1_x_q, s2_x_q, s2_p_q, a_q, b_q;
  logic [2*DATA_W-1:0]   s1_prod_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_W-1:0]     s1_x_d, s2_p_d, a_d, b_d;
  logic [2*DATA_W-1:0]   s1_prod_d;
  logic                  adv;

  assign adv     = !valid_q || ready_i;
  assign ready_o = adv;

  always_comb begin
    s1_x_d    = sel_butterfly_i ? add_mod(a_i, b_i) : a_i;
    s1_prod_d = (2*DATA_W)'(sel_butterfly_i ? sub_mod(a_i, b_i) : b_i)
              * (2*DATA_W)'(twiddle_i);
    s2_p_d    = DATA_W'(s1_prod_q % Q_P);
    a_d       = s2_sel_q ? s2_x_q : add_mod(s2_x_q, s2_p_q);
    b_d       = s2_sel_q ? s2_p_q : sub_mod(s2_x_q, s2_p_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      s1_sel_q   <= 1'b0;
      s2_sel_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_prod_q  <= '0;
      s2_x_q     <= '0;
      s2_p_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
    end else begin
      if (flush_i) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
        valid_q    <= 1'b0;
      end else if (adv) begin
        s1_valid_q <= valid_i;
        s1_sel_q   <= sel_butterfly_i;
        s1_x_q     <= s1_x_d;
        s1_prod_q  <= s1_prod_d;
        s2_valid_q <= s1_valid_q;
        s2_sel_q   <= s1_sel_q;
        s2_x_q     <= s1_x_q;
        s2_p_q     <= s2_p_d;
        valid_q    <= s2_valid_q;
        // Results only load with a real operation so a_o/b_o hold across bubbles.
        if (s2_valid_q) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
      if (valid_q && ready_i && !flush_i) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign valid_o    = valid_q;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy_o     = s1_valid_q || s2_valid_q || valid_q;
  assign op_count_o = cnt_q;

endmodule
`default_nettype wire
